// File: rtl/mybusmatrix5x7_ip_hold.sv
// Input-port address-phase hold stage of the 5x7 bus matrix: forwards a master's
// address phase to the output arbiters and parks it when the arbiter stalls it.
module mybusmatrix5x7_ip_hold (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic        HMASTLOCKS,
  input  logic        HREADYS,
  input  logic        addr_ack_ip,
  input  logic        data_ready_ip,
  input  logic [1:0]  data_resp_ip,
  output logic        sel_op,
  output logic [31:0] HADDR_op,
  output logic [1:0]  HTRANS_op,
  output logic        HWRITE_op,
  output logic [2:0]  HSIZE_op,
  output logic [2:0]  HBURST_op,
  output logic [3:0]  HPROT_op,
  output logic        HMASTLOCK_op,
  output logic        req_op,
  output logic        HREADYOUTS,
  output logic [1:0]  HRESPS
);

  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } ctrl_t;

  ctrl_t live_ctrl;
  ctrl_t held_ctrl;
  ctrl_t fwd_ctrl;

  logic hold_valid;
  logic dphase;
  logic new_tran;
  logic accept;
  logic capture;

  assign live_ctrl = '{
    addr:  HADDRS,
    trans: HTRANSS,
    write: HWRITES,
    size:  HSIZES,
    burst: HBURSTS,
    prot:  HPROTS,
    lock:  HMASTLOCKS
  };

  assign new_tran = HSELS & HREADYS & HTRANSS[1];
  assign accept   = addr_ack_ip & (hold_valid | new_tran);
  // A stalled master cannot present a new transfer, so capture is only legal when empty.
  assign capture  = ~hold_valid & new_tran & ~addr_ack_ip;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hold_valid <= 1'b0;
      held_ctrl  <= '0;
      dphase     <= 1'b0;
    end else begin
      if (capture) begin
        hold_valid <= 1'b1;
        held_ctrl  <= live_ctrl;
      end else if (hold_valid && addr_ack_ip) begin
        hold_valid <= 1'b0;
      end

      // A newly accepted address phase takes priority over the old data phase ending.
      if (accept) begin
        dphase <= 1'b1;
      end else if (data_ready_ip) begin
        dphase <= 1'b0;
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    fwd_ctrl = live_ctrl;
    if (hold_valid) begin
      fwd_ctrl = held_ctrl;
      // A parked SEQ beat is re-arbitrated, so it must look like a burst start.
      if (held_ctrl.trans == TRANS_SEQ) begin
        fwd_ctrl.trans = TRANS_NONSEQ;
      end
    end
  end

  assign sel_op       = hold_valid | (HSELS & HREADYS);
  assign req_op       = hold_valid | new_tran;
  assign HADDR_op     = fwd_ctrl.addr;
  assign HTRANS_op    = fwd_ctrl.trans;
  assign HWRITE_op    = fwd_ctrl.write;
  assign HSIZE_op     = fwd_ctrl.size;
  assign HBURST_op    = fwd_ctrl.burst;
  assign HPROT_op     = fwd_ctrl.prot;
  assign HMASTLOCK_op = fwd_ctrl.lock;

  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = RESP_OKAY;
    if (dphase) begin
      HREADYOUTS = data_ready_ip;
      HRESPS     = data_resp_ip;
    end else if (hold_valid) begin
      HREADYOUTS = 1'b0;
    end
  end

endmodule

// File: tb/tb_mybusmatrix5x7_ip_hold.sv
// Self-checking bench for the input-port hold stage: directed scenarios plus
// randomized traffic checked against a transaction-level reference model.
module tb_mybusmatrix5x7_ip_hold;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        addr_ack_ip;
  logic        data_ready_ip;
  logic [1:0]  data_resp_ip;
  logic        sel_op;
  logic [31:0] HADDR_op;
  logic [1:0]  HTRANS_op;
  logic        HWRITE_op;
  logic [2:0]  HSIZE_op;
  logic [2:0]  HBURST_op;
  logic [3:0]  HPROT_op;
  logic        HMASTLOCK_op;
  logic        req_op;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;

  always #5 HCLK = ~HCLK;

  mybusmatrix5x7_ip_hold dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HSELS        (HSELS),
    .HADDRS       (HADDRS),
    .HTRANSS      (HTRANSS),
    .HWRITES      (HWRITES),
    .HSIZES       (HSIZES),
    .HBURSTS      (HBURSTS),
    .HPROTS       (HPROTS),
    .HMASTLOCKS   (HMASTLOCKS),
    .HREADYS      (HREADYS),
    .addr_ack_ip  (addr_ack_ip),
    .data_ready_ip(data_ready_ip),
    .data_resp_ip (data_resp_ip),
    .sel_op       (sel_op),
    .HADDR_op     (HADDR_op),
    .HTRANS_op    (HTRANS_op),
    .HWRITE_op    (HWRITE_op),
    .HSIZE_op     (HSIZE_op),
    .HBURST_op    (HBURST_op),
    .HPROT_op     (HPROT_op),
    .HMASTLOCK_op (HMASTLOCK_op),
    .req_op       (req_op),
    .HREADYOUTS   (HREADYOUTS),
    .HRESPS       (HRESPS)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: a queue of address phases waiting for the arbiter (at most
  // one, since the master stalls) and a flag saying a data phase is outstanding.
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } xfer_t;

  xfer_t waiting_q[$];
  bit    in_data;

  function automatic xfer_t live_xfer();
    xfer_t x;
    x.addr  = HADDRS;
    x.trans = HTRANSS;
    x.write = HWRITES;
    x.size  = HSIZES;
    x.burst = HBURSTS;
    x.prot  = HPROTS;
    x.lock  = HMASTLOCKS;
    return x;
  endfunction

  function automatic bit is_active_xfer();
    return HSELS && HREADYS && (HTRANSS == 2'b10 || HTRANSS == 2'b11);
  endfunction

  task automatic compare_outputs(input string tag);
    xfer_t x;
    bit    waiting;
    waiting = (waiting_q.size() != 0);
    if (waiting) begin
      x = waiting_q[0];
      x.trans = 2'b10;  // anything waiting is re-offered as a fresh NONSEQ
    end else begin
      x = live_xfer();
    end
    check({tag, ".sel"},   {63'd0, sel_op}, {63'd0, waiting || (HSELS && HREADYS)});
    check({tag, ".req"},   {63'd0, req_op}, {63'd0, waiting || is_active_xfer()});
    check({tag, ".addr"},  {32'd0, HADDR_op}, {32'd0, x.addr});
    check({tag, ".trans"}, {62'd0, HTRANS_op}, {62'd0, x.trans});
    check({tag, ".ctrl"},
          {50'd0, HWRITE_op, HSIZE_op, HBURST_op, HPROT_op, HMASTLOCK_op},
          {50'd0, x.write, x.size, x.burst, x.prot, x.lock});
    check({tag, ".ready"}, {63'd0, HREADYOUTS},
          {63'd0, in_data ? data_ready_ip : !waiting});
    check({tag, ".resp"},  {62'd0, HRESPS}, {62'd0, in_data ? data_resp_ip : 2'b00});
  endtask

  task automatic model_edge();
    bit started;
    if (HRESET) begin
      waiting_q.delete();
      in_data = 0;
      return;
    end
    started = addr_ack_ip && (waiting_q.size() != 0 || is_active_xfer());
    if (waiting_q.size() != 0) begin
      if (addr_ack_ip) void'(waiting_q.pop_front());
    end else if (is_active_xfer() && !addr_ack_ip) begin
      waiting_q.push_back(live_xfer());
    end
    if (started) in_data = 1;
    else if (data_ready_ip) in_data = 0;
  endtask

  // Inputs are set just after a falling edge; outputs are checked before the
  // rising edge, then the model advances on that edge.
  task automatic cycle(input string tag);
    #1;
    compare_outputs(tag);
    @(posedge HCLK);
    model_edge();
    @(negedge HCLK);
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                       input logic wr, input logic [2:0] burst, input logic rdys,
                       input logic ack, input logic dr, input logic [1:0] resp);
    HSELS         = sel;
    HTRANSS       = trans;
    HADDRS        = addr;
    HWRITES       = wr;
    HBURSTS       = burst;
    HSIZES        = 3'b010;
    HPROTS        = 4'h3;
    HMASTLOCKS    = 1'b0;
    HREADYS       = rdys;
    addr_ack_ip   = ack;
    data_ready_ip = dr;
    data_resp_ip  = resp;
  endtask

  task automatic idle(input logic dr, input logic [1:0] resp);
    drive(1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b1, 1'b0, dr, resp);
  endtask

  initial begin
    HRESET = 1'b1;
    idle(1'b1, 2'b00);
    @(negedge HCLK);
    cycle("rst_a");
    cycle("rst_b");
    HRESET = 1'b0;

    // Reset state
    #1;
    check("reset.ready", {63'd0, HREADYOUTS}, 64'd1);
    check("reset.resp",  {62'd0, HRESPS}, 64'd0);
    check("reset.req",   {63'd0, req_op}, 64'd0);
    cycle("reset");

    // Immediate grant
    drive(1'b1, 2'b10, 32'h2000_0000, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 2'b00);
    #1;
    check("grant.req", {63'd0, req_op}, 64'd1);
    cycle("grant_a");
    idle(1'b0, 2'b00);
    #1;
    check("grant.wait", {63'd0, HREADYOUTS}, 64'd0);
    cycle("grant_b");
    idle(1'b1, 2'b00);
    cycle("grant_c");

    // Contention: three stalled cycles, ack on the fourth
    drive(1'b1, 2'b10, 32'h4000_0010, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 2'b00);
    cycle("cont_1");
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'b11, 32'hDEAD_BEE0, 1'b0, 3'b011, 1'b0, 1'b0, 1'b1, 2'b00);
      #1;
      check("cont.addr",  {32'd0, HADDR_op}, 64'h4000_0010);
      check("cont.write", {63'd0, HWRITE_op}, 64'd1);
      check("cont.ready", {63'd0, HREADYOUTS}, 64'd0);
      cycle("cont_hold");
    end
    drive(1'b1, 2'b11, 32'hDEAD_BEE0, 1'b0, 3'b011, 1'b0, 1'b1, 1'b1, 2'b00);
    #1;
    check("cont.ack_addr", {32'd0, HADDR_op}, 64'h4000_0010);
    cycle("cont_4");
    idle(1'b0, 2'b00);
    #1;
    check("cont.dphase_wait", {63'd0, HREADYOUTS}, 64'd0);
    check("cont.released",    {63'd0, req_op}, 64'd0);
    cycle("cont_5");
    idle(1'b1, 2'b00);
    cycle("cont_6");

    // Held SEQ beat of an INCR4 is re-offered as NONSEQ
    drive(1'b1, 2'b11, 32'h0000_0104, 1'b0, 3'b011, 1'b1, 1'b0, 1'b1, 2'b00);
    cycle("seq_1");
    drive(1'b1, 2'b11, 32'h0000_0104, 1'b0, 3'b011, 1'b0, 1'b0, 1'b1, 2'b00);
    #1;
    check("seq.trans", {62'd0, HTRANS_op}, 64'h2);
    check("seq.burst", {61'd0, HBURST_op}, 64'h3);
    cycle("seq_2");
    drive(1'b1, 2'b11, 32'h0000_0104, 1'b0, 3'b011, 1'b0, 1'b1, 1'b1, 2'b00);
    cycle("seq_3");
    idle(1'b1, 2'b00);
    cycle("seq_4");

    // Two-cycle ERROR; master goes IDLE meanwhile
    drive(1'b1, 2'b10, 32'h3000_0000, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 2'b00);
    cycle("err_0");
    drive(1'b1, 2'b00, 32'h3000_0004, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b01);
    #1;
    check("err1.resp",  {62'd0, HRESPS}, 64'h1);
    check("err1.ready", {63'd0, HREADYOUTS}, 64'd0);
    cycle("err_1");
    drive(1'b1, 2'b00, 32'h3000_0004, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 2'b01);
    #1;
    check("err2.resp",  {62'd0, HRESPS}, 64'h1);
    check("err2.ready", {63'd0, HREADYOUTS}, 64'd1);
    cycle("err_2");
    idle(1'b1, 2'b00);
    #1;
    check("err.no_hold", {63'd0, req_op}, 64'd0);
    cycle("err_3");

    // Back-to-back: B accepted on the edge where A completes
    drive(1'b1, 2'b10, 32'h5000_0000, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 2'b00);
    cycle("b2b_a");
    drive(1'b1, 2'b10, 32'h5000_0040, 1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 2'b00);
    cycle("b2b_b");
    idle(1'b0, 2'b10);
    #1;
    check("b2b.dphase_ready", {63'd0, HREADYOUTS}, 64'd0);
    check("b2b.dphase_resp",  {62'd0, HRESPS}, 64'h2);
    cycle("b2b_c");
    idle(1'b1, 2'b00);
    cycle("b2b_d");

    // Reset while holding
    drive(1'b1, 2'b10, 32'h6000_0000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 2'b00);
    cycle("rsth_1");
    drive(1'b1, 2'b10, 32'h6000_0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'b00);
    HRESET = 1'b1;
    cycle("rsth_2");
    HRESET = 1'b0;
    idle(1'b0, 2'b11);
    #1;
    check("rsth.req",   {63'd0, req_op}, 64'd0);
    check("rsth.ready", {63'd0, HREADYOUTS}, 64'd1);
    check("rsth.resp",  {62'd0, HRESPS}, 64'd0);
    cycle("rsth_3");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      HRESET        = ($urandom_range(0, 99) == 0);
      HSELS         = ($urandom_range(0, 3) != 0);
      HADDRS        = $urandom;
      HTRANSS       = 2'($urandom_range(0, 3));
      HWRITES       = 1'($urandom_range(0, 1));
      HSIZES        = 3'($urandom_range(0, 7));
      HBURSTS       = 3'($urandom_range(0, 7));
      HPROTS        = 4'($urandom_range(0, 15));
      HMASTLOCKS    = 1'($urandom_range(0, 1));
      HREADYS       = (waiting_q.size() != 0) ? ($urandom_range(0, 7) == 0)
                                              : ($urandom_range(0, 3) != 0);
      addr_ack_ip   = ($urandom_range(0, 2) == 0);
      data_ready_ip = ($urandom_range(0, 2) != 0);
      data_resp_ip  = 2'($urandom_range(0, 3));
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mybusmatrix5x7_ip_hold.md
MYBUSMATRIX5X7_IP_HOLD -- requirements
Module: mybusmatrix5x7_ip_hold

Interface
REQ-001 SHALL have one clock, HCLK; reset is HRESET, synchronous and active-high.
REQ-002 SHALL have these ports, in order (name, direction, width, meaning):
- HCLK, in, 1, AHB system clock.
- HRESET, in, 1, synchronous active-high reset.
- HSELS, in, 1, master-side slave select.
- HADDRS, in, 32, master address.
- HTRANSS, in, 2, master transfer type.
- HWRITES, in, 1, master write.
- HSIZES, in, 3, master size.
- HBURSTS, in, 3, master burst.
- HPROTS, in, 4, master protection.
- HMASTLOCKS, in, 1, master lock.
- HREADYS, in, 1, master-bus HREADY.
- addr_ack_ip, in, 1, output arbiter accepted this port's address phase this cycle.
- data_ready_ip, in, 1, slave HREADYOUT for this port's data phase.
- data_resp_ip, in, 2, slave HRESP for this port's data phase.
- sel_op, out, 1, select toward output stages.
- HADDR_op, out, 32, forwarded address.
- HTRANS_op, out, 2, forwarded transfer type.
- HWRITE_op, out, 1, forwarded write.
- HSIZE_op, out, 3, forwarded size.
- HBURST_op, out, 3, forwarded burst.
- HPROT_op, out, 4, forwarded protection.
- HMASTLOCK_op, out, 1, forwarded lock.
- req_op, out, 1, arbitration request.
- HREADYOUTS, out, 1, ready returned to master.
- HRESPS, out, 2, response returned to master.

Function
REQ-003 SHALL define new_tran = HSELS & HREADYS & HTRANSS[1] (NONSEQ or SEQ).
REQ-004 SHALL hold state: hold_valid (1b), held control register (addr/trans/write/size/burst/prot/lock), dphase (1b).
REQ-005 SHALL set hold_valid and capture all master address/control on the cycle new_tran=1 and addr_ack_ip=0.
REQ-006 SHALL clear hold_valid on any cycle with hold_valid=1 and addr_ack_ip=1; held register contents then are don't-care.
REQ-007 SHALL drive all *_op signals from the held register while hold_valid=1, else directly from the live master inputs (zero-latency passthrough).
REQ-008 SHALL present a held SEQ as NONSEQ on HTRANS_op (interrupted burst re-arbitrated); held NONSEQ is unchanged.
REQ-009 SHALL drive sel_op = hold_valid | (HSELS & HREADYS), and req_op = hold_valid | new_tran.
REQ-010 SHALL define accept = addr_ack_ip & (hold_valid | new_tran); next dphase = 1 if accept, else 0 if data_ready_ip, else hold; accept wins over simultaneous data_ready_ip.
REQ-011 SHALL drive HREADYOUTS = data_ready_ip when dphase=1; else 0 when hold_valid=1; else 1.
REQ-012 SHALL drive HRESPS = data_resp_ip when dphase=1, else OKAY (2'b00).
REQ-013 SHALL give IDLE/BUSY transfers, and cycles with HSELS=0, a zero-wait OKAY without asserting req_op.
REQ-014 SHALL pass a two-cycle ERROR (ERROR/ready=0 then ERROR/ready=1) unaltered; a master change to IDLE during ERROR does not create a hold.
REQ-015 SHALL keep HMASTLOCK_op equal to the held lock while holding, so a locked sequence keeps its request asserted.
REQ-016 SHALL never capture a new transfer while hold_valid=1 (master is stalled, so HREADYS=0).

Reset
REQ-017 SHALL, on HRESET=1 at a HCLK edge, clear hold_valid, dphase and the held register to 0. The reset outputs are HREADYOUTS=1, HRESPS=00 and req_op=0; a mid-transfer reset drops any pending hold.

Verification
REQ-018 Immediate grant: NONSEQ 0x2000_0000 with addr_ack_ip=1 -> no hold, req_op=1 same cycle, next cycle HREADYOUTS follows data_ready_ip.
REQ-019 Contention: NONSEQ write 0x4000_0010 with addr_ack_ip=0 for 3 cycles -> HADDR_op stays 0x4000_0010, HREADYOUTS=0; ack on cycle 4 -> hold clears, dphase=1.
REQ-020 Held SEQ: INCR4 beat 2 (SEQ, 0x104) not acked -> HTRANS_op=2'b10 while held.
REQ-021 Error: data_resp_ip=01 with ready 0 then 1 -> HRESPS=01 both cycles, HREADYOUTS 0 then 1.
REQ-022 Back-to-back: B accepted on the same edge A's data_ready_ip=1 -> dphase stays 1, no idle gap.
REQ-023 Reset during hold -> next cycle hold_valid=0, req_op=0, HREADYOUTS=1.
